// File: rtl/hazard_freeze_ctrl.sv
// Pipeline stall controller: one-cycle RAW/load-use bubble in ID plus a
// multi-cycle global freeze covering a fixed-latency SRAM access in MEM.
module hazard_freeze_ctrl #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       forward_en,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       two_src,
    input  logic [3:0] EXE_dest,
    input  logic       EXE_WB_en,
    input  logic       EXE_MEM_R_en,
    input  logic [3:0] MEM_dest,
    input  logic       MEM_WB_en,
    input  logic       mem_r_en,
    input  logic       mem_w_en,
    output logic       hazard,
    output logic       freeze,
    output logic       mem_ready,
    output logic       mem_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_r;
    logic [3:0] cnt_r;

    logic m1x_s, m2x_s, m1m_s, m2m_s;
    logic raw_hazard_s;
    logic req_s;
    logic freeze_s;

    // Operand-match terms and RAW hazard selection by forwarding mode
    always_comb begin
        m1x_s = EXE_WB_en & (src1 == EXE_dest);
        m2x_s = two_src & EXE_WB_en & (src2 == EXE_dest);
        m1m_s = MEM_WB_en & (src1 == MEM_dest);
        m2m_s = two_src & MEM_WB_en & (src2 == MEM_dest);
        req_s = mem_r_en | mem_w_en;
        if (forward_en) begin
            // With forwarding only a load still in EXE cannot be bypassed
            raw_hazard_s = EXE_MEM_R_en & (m1x_s | m2x_s);
        end else begin
            raw_hazard_s = m1x_s | m2x_s | m1m_s | m2m_s;
        end
    end

    // Freeze decode: combinational in IDLE so a new access stalls immediately
    always_comb begin
        freeze_s = 1'b0;
        case (state_r)
            IDLE:    freeze_s = req_s;
            ACCESS:  freeze_s = 1'b1;
            DONE:    freeze_s = 1'b0;
            default: freeze_s = 1'b0;
        endcase
    end

    // Output gating: everything is held low while reset is asserted
    always_comb begin
        if (rst) begin
            freeze    = 1'b0;
            hazard    = 1'b0;
            mem_ready = 1'b0;
            mem_busy  = 1'b0;
        end else begin
            freeze    = freeze_s;
            hazard    = raw_hazard_s & ~freeze_s;
            mem_ready = (state_r == DONE);
            mem_busy  = (state_r != IDLE);
        end
    end

    // SRAM access FSM with wait-state down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= ACCESS;
                    end
                end
                // Pipeline advances here; the next MEM instruction is seen in IDLE
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_freeze_ctrl.sv
// Self-checking bench: per-cycle compare against an elapsed-time model of the
// SRAM access plus the stall rules, and directed literal checks.
module tb_hazard_freeze_ctrl;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       forward_en = 1'b0;
    logic [3:0] src1 = 4'd0, src2 = 4'd0, EXE_dest = 4'd0, MEM_dest = 4'd0;
    logic       two_src = 1'b0, EXE_WB_en = 1'b0, EXE_MEM_R_en = 1'b0, MEM_WB_en = 1'b0;
    logic       mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic       hazard, freeze, mem_ready, mem_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_freeze_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .src1(src1), .src2(src2), .two_src(two_src),
        .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en), .EXE_MEM_R_en(EXE_MEM_R_en),
        .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .hazard(hazard), .freeze(freeze), .mem_ready(mem_ready), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Model: m_t = -1 when no access is running, else cycles elapsed since the
    // request was first seen (0 = request cycle).
    int m_t = -1;

    function automatic int cur_t();
        if (m_t >= 0) return m_t;
        return (mem_r_en || mem_w_en) ? 0 : -1;
    endfunction

    function automatic logic exp_freeze();
        int t = cur_t();
        return !rst && t >= 0 && t < W;
    endfunction

    function automatic logic exp_ready();
        return !rst && cur_t() == W;
    endfunction

    function automatic logic exp_busy();
        return !rst && m_t >= 0;
    endfunction

    function automatic logic exp_hazard();
        logic r1x, r2x, r1m, r2m, raw;
        r1x = EXE_WB_en && src1 == EXE_dest;
        r2x = two_src && EXE_WB_en && src2 == EXE_dest;
        r1m = MEM_WB_en && src1 == MEM_dest;
        r2m = two_src && MEM_WB_en && src2 == MEM_dest;
        raw = forward_en ? (EXE_MEM_R_en && (r1x || r2x)) : (r1x || r2x || r1m || r2m);
        return !rst && raw && !exp_freeze();
    endfunction

    always @(posedge clk) begin
        int t;
        t = cur_t();
        if (rst) m_t <= -1;
        else if (t < 0 || t == W) m_t <= -1;
        else m_t <= t + 1;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_hazard", hazard, exp_hazard());
        chk("model_freeze", freeze, exp_freeze());
        chk("model_ready", mem_ready, exp_ready());
        chk("model_busy", mem_busy, exp_busy());
    end

    // Advance to just after the next rising edge; inputs change there
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Literal check of all four outputs at the middle of the current cycle
    task automatic lit(input string name, input logic h, input logic f,
                       input logic r, input logic b);
        @(negedge clk);
        chk({name, "_hazard"}, hazard, h);
        chk({name, "_freeze"}, freeze, f);
        chk({name, "_ready"}, mem_ready, r);
        chk({name, "_busy"}, mem_busy, b);
    endtask

    task automatic clear_inputs();
        forward_en = 1'b0; src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
        EXE_dest = 4'd0; EXE_WB_en = 1'b0; EXE_MEM_R_en = 1'b0;
        MEM_dest = 4'd0; MEM_WB_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        // Reset with conflicting inputs: all outputs forced low
        mem_r_en = 1'b1; src1 = 4'd3; MEM_dest = 4'd3; MEM_WB_en = 1'b1;
        #2;
        lit("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        lit("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            lit("idle", 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Non-forwarding RAW via MEM stage
        src1 = 4'd3; MEM_dest = 4'd3; MEM_WB_en = 1'b1;
        lit("nofwd_src1_mem", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        src1 = 4'd0; src2 = 4'd3; two_src = 1'b0;
        lit("nofwd_src2_unused", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        two_src = 1'b1;
        lit("nofwd_src2_used", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();

        // Forwarding load-use
        forward_en = 1'b1; EXE_dest = 4'd5; EXE_WB_en = 1'b1; src2 = 4'd5;
        two_src = 1'b1; EXE_MEM_R_en = 1'b1;
        lit("fwd_load", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        EXE_MEM_R_en = 1'b0;
        lit("fwd_alu", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        EXE_WB_en = 1'b0; EXE_MEM_R_en = 1'b1; MEM_dest = 4'd5; MEM_WB_en = 1'b1;
        lit("fwd_mem_only", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();
        lit("gap0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // SRAM read, request held high: second access accepted at cycle 6
        mem_r_en = 1'b1;
        lit("rd_c0", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c < W; c++) begin
            step();
            lit("rd_cmid", 1'b0, 1'b1, 1'b0, 1'b1);
        end
        step();
        lit("rd_done", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        lit("rd_next", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        mem_r_en = 1'b0;
        lit("rd_next_busy", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 2; c < W; c++) step();
        step();
        lit("rd_next_done", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        lit("rd_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Freeze masks a load-use hazard during an SRAM write
        forward_en = 1'b1; EXE_dest = 4'd5; EXE_WB_en = 1'b1; EXE_MEM_R_en = 1'b1;
        src1 = 4'd5; mem_w_en = 1'b1;
        lit("mask_c0", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        mem_w_en = 1'b0;
        for (int c = 1; c < W; c++) begin
            lit("mask_cmid", 1'b0, 1'b1, 1'b0, 1'b1);
            step();
        end
        lit("mask_done", 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        lit("mask_idle", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();

        // Reset mid-access with request still high: new access starts
        mem_r_en = 1'b1; mem_w_en = 1'b1;
        lit("rstm_c0", 1'b0, 1'b1, 1'b0, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        lit("rstm_c3", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        lit("rstm_restart", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        lit("rstm_restart_busy", 1'b0, 1'b1, 1'b0, 1'b1);
        step(); step();

        // Reset mid-access with request low: plain idle, no ready pulse
        rst = 1'b1;
        lit("rstm2_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            lit("rstm2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_freeze_ctrl.md
# hazard_freeze_ctrl

Pipeline stall controller for the five-stage core with the SRAM data memory. It issues two kinds of stall. The first is a one-cycle load-use/RAW bubble in ID, which depends on whether operand forwarding is enabled. The second is a multi-cycle global freeze while the MEM stage waits out a fixed-latency SRAM access. The block sits beside the forwarding unit and consumes the same register-tag and write-enable signals. Its outputs drive the IF/ID/EXE/MEM pipeline-register enables and the bubble insertion into ID/EXE.

## Interface
- WAIT_CYCLES, 5: SRAM access latency in cycles; legal range 2..15.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- forward_en  in  1  forwarding enabled; relaxes RAW hazard rules
- src1  in  4  ID-stage first source register tag
- src2  in  4  ID-stage second source register tag
- two_src  in  1  ID instruction actually reads src2
- EXE_dest  in  4  destination tag of instruction in EXE
- EXE_WB_en  in  1  EXE instruction writes the register file
- EXE_MEM_R_en  in  1  EXE instruction is a load
- MEM_dest  in  4  destination tag of instruction in MEM
- MEM_WB_en  in  1  MEM instruction writes the register file
- mem_r_en  in  1  MEM stage requests an SRAM read
- mem_w_en  in  1  MEM stage requests an SRAM write
- hazard  out  1  freeze IF and ID registers; insert a bubble into EXE
- freeze  out  1  hold all pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB)
- mem_ready  out  1  one-cycle pulse: SRAM data valid / write complete
- mem_busy  out  1  access FSM not in IDLE

## Operation
- Operand-match terms:
  - m1x = EXE_WB_en & (src1==EXE_dest)
  - m2x = two_src & EXE_WB_en & (src2==EXE_dest)
  - m1m and m2m are the same terms using MEM_dest/MEM_WB_en.
- raw_hazard when forward_en=0: m1x|m2x|m1m|m2m.
- raw_hazard when forward_en=1: EXE_MEM_R_en & (m1x|m2x). Only a load in EXE stalls.
- hazard = raw_hazard & ~freeze. No bubble is inserted while the whole pipe is frozen.
- req = mem_r_en | mem_w_en.
- Access FSM states: IDLE, ACCESS, DONE.
- 4-bit down-counter cnt.
- IDLE:
  - If req: freeze=1, load cnt=WAIT_CYCLES-1, go to ACCESS.
  - Otherwise stay in IDLE, freeze=0.
- ACCESS:
  - freeze=1.
  - If cnt==1: go to DONE.
  - Otherwise cnt=cnt-1.
- DONE:
  - freeze=0, mem_ready=1.
  - Go to IDLE unconditionally, whatever the state of req.
  - The pipeline advances on this edge, so the next MEM instruction is seen fresh in IDLE.
- A read and a write together count as one request, with the same timing.
- req deasserting mid-ACCESS has no effect. The access always completes.
- mem_busy = (state != IDLE).

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0.
  - While rst is high, freeze, hazard, mem_ready and mem_busy are all forced to 0.
- Reset asserted in ACCESS or DONE aborts the access. mem_ready is not pulsed.
- hazard, and freeze while in IDLE, are combinational from the inputs, with no latency.
- All other outputs are decoded from registered state.
- A request first seen at cycle 0 in IDLE gives:
  - freeze=1 for cycles 0..WAIT_CYCLES-1 (exactly WAIT_CYCLES cycles);
  - mem_ready=1 and freeze=0 at cycle WAIT_CYCLES;
  - IDLE at cycle WAIT_CYCLES+1.
- Back-to-back memory instructions: the second request is seen at WAIT_CYCLES+1. The gap is one non-frozen cycle (DONE) per access.
- Simultaneous RAW hazard and new memory request in IDLE: freeze wins, hazard=0. The hazard is re-evaluated in the DONE cycle.

## Test plan
- Reset then idle:
  - rst=1 for 2 cycles, then all inputs 0.
  - All outputs stay 0 and mem_busy=0.
- Non-forwarding RAW:
  - forward_en=0, src1=3, MEM_dest=3, MEM_WB_en=1: hazard=1.
  - Same, but only src2=3 and two_src=0: hazard=0.
- Forwarding load-use:
  - forward_en=1, EXE_dest=5, EXE_WB_en=1, src2=5, two_src=1.
  - hazard=1 when EXE_MEM_R_en=1; hazard=0 when EXE_MEM_R_en=0.
  - MEM match alone gives hazard=0.
- SRAM read, WAIT_CYCLES=5:
  - mem_r_en held high from cycle 0.
  - freeze=1 in cycles 0-4; mem_ready=1 and freeze=0 in cycle 5; mem_busy=1 in cycles 1-5.
  - Next request is accepted at cycle 6.
- Freeze masks hazard:
  - Load-use hazard condition held during an SRAM write.
  - hazard=0 in cycles 0-4 and hazard=1 in cycle 5.
- Reset mid-access:
  - rst=1 at cycle 3 of an access.
  - Next cycle: state IDLE, no mem_ready pulse; freeze=0 unless req is still high, in which case a new access starts.
